// File: rtl/alu_multicycle_if.sv
// Handshake and operand/result bundle between the ALU control FSM (master)
// and the multicycle ALU datapath (slave).
interface alu_multicycle_if #(
   parameter int unsigned WIDTH = 16
) ();
   logic             start;
   logic [3:0]       operation;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             zero;
   logic             lt;
   logic             overflow;
   logic             div_by_zero;

   modport master (
      output start, operation, a, b,
      input  busy, done, result, result_hi, zero, lt, overflow, div_by_zero
   );

   modport slave (
      input  start, operation, a, b,
      output busy, done, result, result_hi, zero, lt, overflow, div_by_zero
   );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith ops plus shift-add multiply and
// restoring divide, one bit per cycle, behind a start/busy/done handshake.
module alu_multicycle #(
   parameter int unsigned WIDTH = 16
) (
   input logic              clk,
   input logic              reset,
   alu_multicycle_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
   typedef enum logic [3:0] {
      OP_NOP  = 4'b0000, OP_ADD  = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0011,
      OP_DIV  = 4'b0100, OP_MOVE = 4'b0101, OP_SWAP = 4'b0110, OP_AND = 4'b0111,
      OP_OR   = 4'b1000, OP_CMP  = 4'b1001
   } op_t;

   state_t           state, state_n;
   op_t              op;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH-1:0] hi, hi_n, lo, lo_n, opnd, opnd_n;
   logic             busy_q, busy_n, done_q, done_n;
   logic [WIDTH-1:0] res_q, res_n, rhi_q, rhi_n;
   logic             zero_q, zero_n, lt_q, lt_n, ov_q, ov_n, dbz_q, dbz_n;

   logic [WIDTH-1:0] add_r, sub_r;
   logic [WIDTH-1:0] s_res, s_hi;
   logic             s_zero, s_lt, s_ov, s_dbz;
   logic [WIDTH:0]   mul_add;
   logic [2*WIDTH-1:0] mul_step;
   logic [WIDTH:0]   div_shift, div_diff;
   logic [WIDTH-1:0] div_rem, div_quo;

   assign op    = op_t'(bus.operation);
   assign add_r = bus.a + bus.b;
   assign sub_r = bus.a - bus.b;

   // hi accumulates the partial product; lo shifts out multiplier bits and
   // shifts in product bits, so {hi,lo} ends as the full product.
   assign mul_add  = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
   assign mul_step = {mul_add, lo[WIDTH-1:1]};

   // Restoring divide: hi is the partial remainder, lo shifts dividend out
   // and quotient bits in. A set top bit of div_diff means it went negative.
   assign div_shift = {hi, lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
   assign div_quo   = {lo[WIDTH-2:0], ~div_diff[WIDTH]};

   always_comb begin
      s_res = '0;
      s_hi  = '0;
      s_lt  = 1'b0;
      s_ov  = 1'b0;
      s_dbz = 1'b0;
      case (op)
         OP_ADD: begin
            s_res = add_r;
            s_ov  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            s_res = sub_r;
            s_ov  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_DIV: begin
            s_res = '1;
            s_hi  = bus.a;
            s_dbz = 1'b1;
         end
         OP_MOVE: s_res = bus.a;
         OP_SWAP: begin
            s_res = bus.b;
            s_hi  = bus.a;
         end
         OP_AND: s_res = bus.a & bus.b;
         OP_OR:  s_res = bus.a | bus.b;
         OP_CMP: begin
            s_res = sub_r;
            s_lt  = $signed(bus.a) < $signed(bus.b);
         end
         default: ;
      endcase
      s_zero = (op == OP_CMP) ? (bus.a == bus.b) : (s_res == '0);
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hi_n    = hi;
      lo_n    = lo;
      opnd_n  = opnd;
      busy_n  = busy_q;
      done_n  = 1'b0;
      res_n   = res_q;
      rhi_n   = rhi_q;
      zero_n  = zero_q;
      lt_n    = lt_q;
      ov_n    = ov_q;
      dbz_n   = dbz_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if ((op == OP_MUL) || ((op == OP_DIV) && (bus.b != '0))) begin
                  hi_n    = '0;
                  lo_n    = bus.a;
                  opnd_n  = bus.b;
                  cnt_n   = CW'(WIDTH);
                  busy_n  = 1'b1;
                  state_n = (op == OP_MUL) ? MUL : DIV;
               end else begin
                  res_n  = s_res;
                  rhi_n  = s_hi;
                  zero_n = s_zero;
                  lt_n   = s_lt;
                  ov_n   = s_ov;
                  dbz_n  = s_dbz;
                  done_n = 1'b1;
               end
            end
         end
         MUL, DIV: begin
            if (state == MUL) begin
               hi_n = mul_step[2*WIDTH-1:WIDTH];
               lo_n = mul_step[WIDTH-1:0];
            end else begin
               hi_n = div_rem;
               lo_n = div_quo;
            end
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               res_n   = lo_n;
               rhi_n   = hi_n;
               zero_n  = (lo_n == '0);
               lt_n    = 1'b0;
               ov_n    = 1'b0;
               dbz_n   = 1'b0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         opnd   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         res_q  <= '0;
         rhi_q  <= '0;
         zero_q <= 1'b0;
         lt_q   <= 1'b0;
         ov_q   <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         hi     <= hi_n;
         lo     <= lo_n;
         opnd   <= opnd_n;
         busy_q <= busy_n;
         done_q <= done_n;
         res_q  <= res_n;
         rhi_q  <= rhi_n;
         zero_q <= zero_n;
         lt_q   <= lt_n;
         ov_q   <= ov_n;
         dbz_q  <= dbz_n;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.result      = res_q;
   assign bus.result_hi   = rhi_q;
   assign bus.zero        = zero_q;
   assign bus.lt          = lt_q;
   assign bus.overflow    = ov_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle with hand-computed expectations.
module tb_alu_multicycle;
   localparam int unsigned W = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   alu_multicycle_if #(.WIDTH(W)) bus ();
   alu_multicycle #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one op; returns cycles until done (1 = visible right after the
   // sampling edge) and how many of those cycles showed busy. Operands are
   // scrambled after acceptance to prove they are latched.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         output int cyc, output int bcyc);
      bus.start = 1'b1; bus.operation = op; bus.a = aa; bus.b = bb;
      cyc = 0; bcyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            bus.start = 1'b0; bus.a = ~aa; bus.b = ~bb;
         end
         if (bus.busy) bcyc++;
      end while (!bus.done && cyc < 40);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if ({bus.busy, bus.done, bus.zero, bus.lt, bus.overflow, bus.div_by_zero} !== 6'b0) begin
         miscompares++; $display("FAIL reset_flags: got %b expected 000000",
            {bus.busy, bus.done, bus.zero, bus.lt, bus.overflow, bus.div_by_zero});
      end
      vectors++;
      if ({bus.result_hi, bus.result} !== 32'h0) begin
         miscompares++; $display("FAIL reset_result: got %h expected 00000000", {bus.result_hi, bus.result});
      end
   endtask

   task automatic test_add_sub();
      int c, bc;
      run_op(4'b0001, 16'h7FFF, 16'h0001, c, bc);
      vectors++;
      if (c !== 1 || bus.result !== 16'h8000 || bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin
         miscompares++; $display("FAIL add_ovf: cyc=%0d res=%h ov=%b z=%b expected 1 8000 1 0",
            c, bus.result, bus.overflow, bus.zero);
      end
      run_op(4'b0010, 16'd5, 16'd5, c, bc);
      vectors++;
      if (c !== 1 || bus.result !== 16'h0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin
         miscompares++; $display("FAIL sub_zero: cyc=%0d res=%h z=%b ov=%b expected 1 0000 1 0",
            c, bus.result, bus.zero, bus.overflow);
      end
      run_op(4'b0010, 16'h8000, 16'h0001, c, bc);
      vectors++;
      if (bus.result !== 16'h7FFF || bus.overflow !== 1'b1) begin
         miscompares++; $display("FAIL sub_ovf: res=%h ov=%b expected 7fff 1", bus.result, bus.overflow);
      end
   endtask

   task automatic test_mult();
      int c, bc;
      run_op(4'b0011, 16'hFFFF, 16'hFFFF, c, bc);
      vectors++;
      if (c !== 17 || bc !== 16) begin
         miscompares++; $display("FAIL mult_timing: cyc=%0d busy=%0d expected 17 16", c, bc);
      end
      vectors++;
      if (bus.result_hi !== 16'hFFFE || bus.result !== 16'h0001 || bus.zero !== 1'b0) begin
         miscompares++; $display("FAIL mult_max: got %h_%h z=%b expected fffe_0001 0",
            bus.result_hi, bus.result, bus.zero);
      end
      run_op(4'b0011, 16'd7, 16'd9, c, bc);
      vectors++;
      if (c !== 17 || bus.result !== 16'd63 || bus.result_hi !== 16'd0) begin
         miscompares++; $display("FAIL mult_small: cyc=%0d got %h_%h expected 17 0000_003f",
            c, bus.result_hi, bus.result);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.done !== 1'b0 || bus.result !== 16'd63) begin
         miscompares++; $display("FAIL mult_done_pulse: done=%b res=%h expected 0 003f", bus.done, bus.result);
      end
   endtask

   task automatic test_div();
      int c, bc;
      run_op(4'b0100, 16'd100, 16'd7, c, bc);
      vectors++;
      if (c !== 17 || bus.result !== 16'd14 || bus.result_hi !== 16'd2 || bus.div_by_zero !== 1'b0) begin
         miscompares++; $display("FAIL div_basic: cyc=%0d q=%h r=%h dbz=%b expected 17 000e 0002 0",
            c, bus.result, bus.result_hi, bus.div_by_zero);
      end
      run_op(4'b0100, 16'd5, 16'd9, c, bc);
      vectors++;
      if (bus.result !== 16'd0 || bus.result_hi !== 16'd5 || bus.zero !== 1'b1) begin
         miscompares++; $display("FAIL div_small: q=%h r=%h z=%b expected 0000 0005 1",
            bus.result, bus.result_hi, bus.zero);
      end
      run_op(4'b0100, 16'h1234, 16'h0000, c, bc);
      vectors++;
      if (c !== 1 || bc !== 0 || bus.result !== 16'hFFFF || bus.result_hi !== 16'h1234
          || bus.div_by_zero !== 1'b1 || bus.zero !== 1'b0) begin
         miscompares++; $display("FAIL div_by_zero: cyc=%0d busy=%0d q=%h r=%h dbz=%b z=%b expected 1 0 ffff 1234 1 0",
            c, bc, bus.result, bus.result_hi, bus.div_by_zero, bus.zero);
      end
   endtask

   task automatic test_ignore_busy();
      int c = 0;
      int dones = 0;
      bus.start = 1'b1; bus.operation = 4'b0011; bus.a = 16'd3; bus.b = 16'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b1; bus.operation = 4'b0001; bus.a = 16'd1; bus.b = 16'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      while (!bus.done && c < 40) begin
         @(posedge clk); #1; c++;
      end
      vectors++;
      if (bus.result !== 16'd15 || bus.result_hi !== 16'd0 || c !== 12) begin
         miscompares++; $display("FAIL ignore_busy: res=%h hi=%h wait=%0d expected 000f 0000 12",
            bus.result, bus.result_hi, c);
      end
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      vectors++;
      if (dones !== 0 || bus.result !== 16'd15) begin
         miscompares++; $display("FAIL ignore_no_extra: dones=%0d res=%h expected 0 000f", dones, bus.result);
      end
   endtask

   task automatic test_reset_abort();
      int dones = 0;
      bus.start = 1'b1; bus.operation = 4'b0011; bus.a = 16'hFFFF; bus.b = 16'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if ({bus.busy, bus.done, bus.zero, bus.lt, bus.overflow, bus.div_by_zero} !== 6'b0
          || {bus.result_hi, bus.result} !== 32'h0) begin
         miscompares++; $display("FAIL reset_abort: busy=%b done=%b res=%h_%h expected 0 0 0000_0000",
            bus.busy, bus.done, bus.result_hi, bus.result);
      end
      reset = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         miscompares++; $display("FAIL reset_no_done: active cycles=%0d expected 0", dones);
      end
   endtask

   task automatic test_misc_ops();
      int c, bc;
      run_op(4'b1001, 16'hFFFE, 16'd3, c, bc);
      vectors++;
      if (bus.lt !== 1'b1 || bus.zero !== 1'b0 || bus.result !== 16'hFFFB) begin
         miscompares++; $display("FAIL cmp_lt: lt=%b z=%b res=%h expected 1 0 fffb", bus.lt, bus.zero, bus.result);
      end
      run_op(4'b1001, 16'd3, 16'd3, c, bc);
      vectors++;
      if (bus.lt !== 1'b0 || bus.zero !== 1'b1) begin
         miscompares++; $display("FAIL cmp_eq: lt=%b z=%b expected 0 1", bus.lt, bus.zero);
      end
      run_op(4'b0110, 16'hAAAA, 16'h5555, c, bc);
      vectors++;
      if (bus.result !== 16'h5555 || bus.result_hi !== 16'hAAAA || bus.lt !== 1'b0) begin
         miscompares++; $display("FAIL swap: got %h_%h lt=%b expected aaaa_5555 0", bus.result_hi, bus.result, bus.lt);
      end
      run_op(4'b0111, 16'hF0F0, 16'h3C3C, c, bc);
      vectors++;
      if (bus.result !== 16'h3030 || bus.result_hi !== 16'h0) begin
         miscompares++; $display("FAIL and: got %h_%h expected 0000_3030", bus.result_hi, bus.result);
      end
      run_op(4'b1000, 16'hF0F0, 16'h3C3C, c, bc);
      vectors++;
      if (bus.result !== 16'hFCFC) begin
         miscompares++; $display("FAIL or: got %h expected fcfc", bus.result);
      end
      run_op(4'b0101, 16'h1234, 16'h9999, c, bc);
      vectors++;
      if (bus.result !== 16'h1234 || bus.result_hi !== 16'h0) begin
         miscompares++; $display("FAIL move: got %h_%h expected 0000_1234", bus.result_hi, bus.result);
      end
      run_op(4'b1100, 16'd5, 16'd6, c, bc);
      vectors++;
      if (c !== 1 || bus.result !== 16'h0 || bus.zero !== 1'b1) begin
         miscompares++; $display("FAIL undef_op: cyc=%0d res=%h z=%b expected 1 0000 1", c, bus.result, bus.zero);
      end
      run_op(4'b0000, 16'd5, 16'd6, c, bc);
      vectors++;
      if (c !== 1 || bus.result !== 16'h0 || bus.result_hi !== 16'h0 || bus.zero !== 1'b1) begin
         miscompares++; $display("FAIL nop: cyc=%0d got %h_%h z=%b expected 1 0000_0000 1",
            c, bus.result_hi, bus.result, bus.zero);
      end
   endtask

   task automatic test_back_to_back();
      int c = 0;
      bus.start = 1'b1; bus.operation = 4'b0001; bus.a = 16'd2; bus.b = 16'd3;
      @(posedge clk); #1;
      vectors++;
      if (bus.done !== 1'b1 || bus.result !== 16'd5) begin
         miscompares++; $display("FAIL b2b_add: done=%b res=%h expected 1 0005", bus.done, bus.result);
      end
      bus.operation = 4'b0011; bus.a = 16'd6; bus.b = 16'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      vectors++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         miscompares++; $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", bus.busy, bus.done);
      end
      c = 1;
      while (!bus.done && c < 40) begin
         @(posedge clk); #1; c++;
      end
      vectors++;
      if (c !== 17 || bus.result !== 16'd42) begin
         miscompares++; $display("FAIL b2b_mult: cyc=%0d res=%h expected 17 002a", c, bus.result);
      end
      bus.start = 1'b1; bus.operation = 4'b0010; bus.a = 16'd10; bus.b = 16'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      vectors++;
      if (bus.done !== 1'b1 || bus.result !== 16'd6 || bus.result_hi !== 16'd0) begin
         miscompares++; $display("FAIL b2b_sub: done=%b got %h_%h expected 1 0000_0006",
            bus.done, bus.result_hi, bus.result);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.operation = 4'b0000; bus.a = '0; bus.b = '0;
      test_reset();
      test_add_sub();
      test_mult();
      test_div();
      test_ignore_busy();
      test_reset_abort();
      test_misc_ops();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
